// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_fb_arbiter
// Brief   : Frame-buffer arbiter; line prefetch into a line buffer has strict
//           priority over a single-beat, zero-latency pixel writer.
// Rev     : 1.0
// ============================================================================
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input  logic              MAX10_CLK1_50,
    input  logic              RESET,
    input  logic              line_req,
    input  logic [9:0]        line_num,
    output logic              line_done,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overrun
);

    localparam logic [10:0]     c_V_LIMIT  = 11'(V_ACTIVE);
    localparam logic [9:0]      c_LAST_PIX = 10'(H_ACTIVE - 1);
    localparam logic [ADDR_W:0] c_FB_SIZE  = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic                pend_q;
    logic [9:0]          pend_line_q;
    logic [ADDR_W-1:0]   base_q;
    logic [9:0]          rd_cnt_q;
    logic [9:0]          rd_cnt_d;
    logic                lb_we_q;
    logic [9:0]          lb_addr_q;
    logic                line_done_q;
    logic                overrun_q;

    logic [ADDR_W-1:0]   w_line_ext;
    logic [ADDR_W-1:0]   w_base;
    logic                w_line_ok;
    logic                w_req_take;
    logic                w_req_drop;
    logic                w_wr_fire;
    logic                w_wr_in_range;

    assign w_line_ext    = ADDR_W'(pend_line_q);
    assign w_line_ok     = ({1'b0, line_num} < c_V_LIMIT);
    assign w_req_take    = line_req && !pend_q && w_line_ok;
    assign w_req_drop    = line_req && !w_req_take;
    assign rd_cnt_d      = rd_cnt_q + 10'd1;
    assign w_wr_in_range = ({1'b0, wr_addr} < c_FB_SIZE);

    // Line base address: the default width is a sum of three shifted copies.
    generate
        if (H_ACTIVE == 800) begin : g_base_shift
            assign w_base = (w_line_ext << 9) + (w_line_ext << 8) + (w_line_ext << 5);
        end else begin : g_base_mul
            assign w_base = w_line_ext * ADDR_W'(H_ACTIVE);
        end
    endgenerate

    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            base_q      <= '0;
            rd_cnt_q    <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // The line buffer lags the read address by the frame-buffer latency.
            lb_we_q     <= (state_q == S_FETCH);
            lb_addr_q   <= (state_q == S_FETCH) ? rd_cnt_q : '0;
            line_done_q <= (state_q == S_FETCH) && (rd_cnt_q == c_LAST_PIX);

            if (w_req_take) begin
                pend_q      <= 1'b1;
                pend_line_q <= line_num;
            end else if (state_q == S_IDLE) begin
                pend_q      <= 1'b0;
            end

            if (w_req_drop) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_q  <= S_FETCH;
                        base_q   <= w_base;
                        rd_cnt_q <= '0;
                    end
                end
                S_FETCH: begin
                    rd_cnt_q <= rd_cnt_d;
                    if (rd_cnt_q == c_LAST_PIX) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready  = (state_q == S_IDLE) && !pend_q;
    assign w_wr_fire = wr_valid && wr_ready && !RESET;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == S_FETCH) begin
            mem_addr = base_q + ADDR_W'(rd_cnt_q);
        end else if (w_wr_fire) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_we    = w_wr_in_range;
        end
    end

    assign lb_we     = lb_we_q;
    assign lb_addr   = lb_addr_q;
    assign lb_data   = lb_we_q ? mem_rdata : '0;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_fb_arbiter
// Brief   : Scoreboard bench for vga_fb_arbiter with a transaction-level model.
// Rev     : 1.0
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int H       = 800;
    localparam int V       = 600;
    localparam int AW      = 19;
    localparam int DW      = 12;
    localparam int FB_SIZE = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_req;
    logic [9:0]    line_num;
    logic          line_done;
    logic          lb_we;
    logic [9:0]    lb_addr;
    logic [DW-1:0] lb_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          overrun;

    vga_fb_arbiter #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (rst),
        .line_req      (line_req),
        .line_num      (line_num),
        .line_done     (line_done),
        .lb_we         (lb_we),
        .lb_addr       (lb_addr),
        .lb_data       (lb_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Frame-buffer contents are a fixed function of address; one-cycle read latency.
    function automatic logic [DW-1:0] pix(input int unsigned a);
        int unsigned h;
        h = a * 37 + (a >> 7) + 5;
        return h[DW-1:0];
    endfunction

    always @(posedge clk) mem_rdata <= pix(32'(mem_addr));

    typedef struct {
        int unsigned cyc;
        int unsigned addr;
        int unsigned data;
        bit          done;
    } ev_t;

    ev_t rdq[$];
    ev_t lbq[$];
    ev_t wrq[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    bit          mon_en = 1'b0;

    // Transaction-level model: pending slot, remaining busy cycles, sticky error.
    bit          m_pend      = 1'b0;
    int          m_pend_line = 0;
    int          m_busy      = 0;
    bit          m_overrun   = 1'b0;
    int unsigned m_fstart    = 0;
    bit          prev_lr     = 1'b0;
    int          prev_ln     = 0;
    bit          cur_fire    = 1'b0;

    function automatic ev_t mk_ev(input int unsigned c, input int unsigned a,
                                  input int unsigned d, input bit dn);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        e.done = dn;
        return e;
    endfunction

    function automatic bit exp_ready();
        return (m_busy == 0) && !m_pend;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model across one rising edge using the inputs of the cycle just ended.
    task automatic model_step();
        bit          pend_old;
        int unsigned base;
        pend_old = m_pend;
        if (m_busy > 0) begin
            m_busy--;
        end else if (m_pend) begin
            base     = int'(m_pend_line) * H;
            m_pend   = 1'b0;
            m_busy   = H + 1;
            m_fstart = cyc;
            for (int i = 0; i < H; i++) begin
                rdq.push_back(mk_ev(cyc + 1 + i, base + i, 0, 1'b0));
                lbq.push_back(mk_ev(cyc + 2 + i, i, pix(base + i), i == H - 1));
            end
        end
        if (prev_lr) begin
            if (!pend_old && prev_ln < V) begin
                m_pend      = 1'b1;
                m_pend_line = prev_ln;
            end else begin
                m_overrun = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit lr, input int ln, input bit wv,
                        input int unsigned wa, input int unsigned wd);
        @(negedge clk);
        model_step();
        line_req = lr;
        line_num = 10'(ln);
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = DW'(wd);
        prev_lr  = lr;
        prev_ln  = ln;
        cur_fire = wv && exp_ready();
        if (cur_fire && wa < FB_SIZE) wrq.push_back(mk_ev(cyc, wa, wd, 1'b0));
    endtask

    function automatic int unsigned rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom_range(FB_SIZE, (1 << AW) - 1);
        return $urandom_range(0, FB_SIZE - 1);
    endfunction

    task automatic rand_idle_step();
        step(1'b0, 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 4095));
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((m_busy > 0 || m_pend || rdq.size() > 0 || lbq.size() > 0 || wrq.size() > 0)
               && n < maxc) begin
            rand_idle_step();
            n++;
        end
        chk("drain_in_budget", 32'(n < maxc), 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_lb_we", lb_we, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_lb_addr", lb_addr, 0);
        chk("rst_lb_data", lb_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wr_ready", wr_ready, 1);
    endtask

    // Monitor: compares every DUT output against the scoreboard queues each cycle.
    initial begin
        ev_t e;
        bit  rd_exp;
        bit  wr_exp;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("wr_ready", wr_ready, exp_ready());
                chk("overrun", overrun, m_overrun);
                rd_exp = rdq.size() > 0 && rdq[0].cyc == cyc;
                wr_exp = wrq.size() > 0 && wrq[0].cyc == cyc;
                if (rd_exp) begin
                    e = rdq.pop_front();
                    chk("rd_addr", mem_addr, e.addr);
                    chk("rd_mem_we", mem_we, 0);
                end
                if (wr_exp) begin
                    e = wrq.pop_front();
                    chk("wr_mem_we", mem_we, 1);
                    chk("wr_mem_addr", mem_addr, e.addr);
                    chk("wr_mem_wdata", mem_wdata, e.data);
                end else if (!rd_exp) begin
                    chk("idle_mem_we", mem_we, 0);
                    if (!cur_fire) begin
                        chk("idle_mem_addr", mem_addr, 0);
                        chk("idle_mem_wdata", mem_wdata, 0);
                    end
                end
                if (lbq.size() > 0 && lbq[0].cyc == cyc) begin
                    e = lbq.pop_front();
                    chk("lb_we", lb_we, 1);
                    chk("lb_addr", lb_addr, e.addr);
                    chk("lb_data", lb_data, e.data);
                    chk("line_done", line_done, e.done);
                end else begin
                    chk("idle_lb_we", lb_we, 0);
                    chk("idle_line_done", line_done, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst      = 1'b1;
        line_req = 1'b0;
        line_num = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        repeat (3) @(negedge clk);
        #2;
        chk_reset_outputs();
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Random writes, including out-of-range ones.
        for (int i = 0; i < 60; i++) rand_idle_step();
        step(1'b0, 0, 1'b1, FB_SIZE, 123);
        step(1'b0, 0, 1'b1, FB_SIZE - 1, 77);
        step(1'b0, 0, 1'b0, 0, 0);

        // Fetch of line 1 against a writer that never lets go of wr_valid.
        step(1'b1, 1, 1'b1, $urandom_range(0, FB_SIZE - 1), $urandom_range(0, 4095));
        for (int i = 0; i < 810; i++)
            step(1'b0, 0, 1'b1, $urandom_range(0, FB_SIZE - 1), $urandom_range(0, 4095));
        drain(2000);

        // Last valid line, then one past the end.
        step(1'b1, V - 1, 1'b0, 0, 0);
        drain(2000);
        step(1'b1, V, 1'b1, 5, 5);
        repeat (5) rand_idle_step();

        // Random mix of requests and writes.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 399) == 0), $urandom_range(0, 639),
                 1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 4095));
        drain(3000);

        // Reset asserted while rd_cnt is 400.
        step(1'b1, 3, 1'b0, 0, 0);
        guard = 0;
        while (!(m_busy > 0 && cyc == m_fstart + 401) && guard < 2000) begin
            step(1'b0, 0, 1'b0, 0, 0);
            guard++;
        end
        chk("reach_rd_cnt_400", 32'(guard < 2000), 1);
        #3;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        rdq.delete();
        lbq.delete();
        wrq.delete();
        m_pend    = 1'b0;
        m_busy    = 0;
        m_overrun = 1'b0;
        prev_lr   = 1'b0;
        cur_fire  = 1'b0;
        cyc++;
        mon_en    = 1'b1;

        step(1'b1, 7, 1'b0, 0, 0);
        drain(2000);

        // Queuing: second request mid-fetch waits, third overflows the slot.
        step(1'b1, 5, 1'b0, 0, 0);
        repeat (300) rand_idle_step();
        step(1'b1, 10, 1'b0, 0, 0);
        repeat (100) rand_idle_step();
        step(1'b1, 20, 1'b0, 0, 0);
        drain(3000);
        repeat (3) rand_idle_step();

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
